uart_tx_arbiter: RTL

//  Shares one uart_tx serializer between NUM_REQ byte sources (loopback echo path, status

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ sources.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [2:0]           o_Owner,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    localparam int                 c_TMO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]         c_GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [2:0]         c_OWNER_RST = 3'(NUM_REQ - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_LAUNCH    = 2'd1;
    localparam logic [1:0] c_WAIT_DONE = 2'd2;
    localparam logic [1:0] c_GAP       = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [2:0]         r_owner;
    logic [7:0]         r_tx_byte;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_tx_dv;
    logic               r_timeout;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [7:0]         r_gap_cnt;

    logic               w_found;
    logic [2:0]         w_pick;
    logic [7:0]         w_pick_byte;
    int                 w_best;
    int                 w_dist;
    logic               w_launch;
    logic               w_tmo_hit;
    logic               w_gap_end;
    logic [NUM_REQ-1:0] w_grant_next;
    logic               w_tx_dv_next;
    logic               w_timeout_next;

    // Round-robin pick: the requester closest after the current owner wins.
    always_comb begin
        w_found     = 1'b0;
        w_pick      = r_owner;
        w_pick_byte = 8'h00;
        w_best      = NUM_REQ;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + 2 * NUM_REQ - int'(r_owner) - 1) % NUM_REQ;
            if (i_Req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_found     = 1'b1;
                w_pick      = 3'(i);
                w_pick_byte = i_Req_Byte[8*i +: 8];
            end
        end
    end

    assign w_launch  = (r_state == c_IDLE) && w_found && !i_Tx_Active;
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);
    assign w_gap_end = (r_gap_cnt == c_GAP_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_launch) begin
                    w_state_next = c_LAUNCH;
                end
            end
            c_LAUNCH: begin
                w_state_next = c_WAIT_DONE;
            end
            c_WAIT_DONE: begin
                // Done has priority over a simultaneous timeout.
                if (i_Tx_Done) begin
                    w_state_next = (GAP_CYCLES == 0) ? c_IDLE : c_GAP;
                end else if (w_tmo_hit) begin
                    w_state_next = c_IDLE;
                end
            end
            c_GAP: begin
                if (w_gap_end) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tx_dv_next   = (r_state == c_LAUNCH);
        w_timeout_next = (r_state == c_WAIT_DONE) && !i_Tx_Done && w_tmo_hit;
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign w_grant_next[gi] = (r_state == c_LAUNCH) && (r_owner == 3'(gi));
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_owner   <= c_OWNER_RST;
            r_tx_byte <= 8'h00;
            r_grant   <= '0;
            r_tx_dv   <= 1'b0;
            r_timeout <= 1'b0;
            r_tmo_cnt <= '0;
            r_gap_cnt <= 8'h00;
        end else begin
            if (w_launch) begin
                r_owner   <= w_pick;
                r_tx_byte <= w_pick_byte;
            end
            r_grant   <= w_grant_next;
            r_tx_dv   <= w_tx_dv_next;
            r_timeout <= w_timeout_next;
            r_tmo_cnt <= (r_state == c_WAIT_DONE) ? r_tmo_cnt + 1'b1 : '0;
            r_gap_cnt <= (r_state == c_GAP) ? r_gap_cnt + 8'h01 : 8'h00;
        end
    end

    assign o_Grant   = r_grant;
    assign o_Tx_DV   = r_tx_dv;
    assign o_Tx_Byte = r_tx_byte;
    assign o_Owner   = r_owner;
    assign o_Busy    = (r_state != c_IDLE);
    assign o_Timeout = r_timeout;

endmodule
`default_nettype wire
